// File: rtl/ram_io_if.sv
// ram_io_if: core request/response and cache word-port signals of the load/store adapter.
interface ram_io_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] cache_address;
    logic [31:0] cache_data_in;
    logic [3:0]  cache_write_enable;
    logic [31:0] cache_data_out;
    logic        cache_data_out_ready;
    logic        cache_busy;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  cache_data_out, cache_data_out_ready, cache_busy,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output cache_address, cache_data_in, cache_write_enable
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output cache_data_out, cache_data_out_ready, cache_busy,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  cache_address, cache_data_in, cache_write_enable
    );
endinterface

// File: rtl/ram_io.sv
// ram_io: byte/halfword/word load-store adapter onto the 32-bit cache word port.
module ram_io #(
    parameter int SETTLE_CYCLES = 1
) (
    input logic clk,
    input logic rst,
    ram_io_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, READ_WAIT, WRITE_WAIT} state_t;

    state_t      state, state_nx;
    logic [1:0]  cnt, lane, size;
    logic        sgn, wr;
    logic        accept, bad, done;
    logic [3:0]  mask;
    logic [31:0] din, ldata;
    logic [7:0]  b;
    logic [15:0] h;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = accept && !bad ? SETTLE : IDLE;
            SETTLE:     state_nx = cnt != 2'd0 ? SETTLE : wr ? WRITE_WAIT : READ_WAIT;
            READ_WAIT:  state_nx = done ? IDLE : READ_WAIT;
            WRITE_WAIT: state_nx = done ? IDLE : WRITE_WAIT;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = state == IDLE && !bus.cache_busy && !rst;
    end

    always_comb begin
        accept = bus.req_valid && state == IDLE && !bus.cache_busy;
        done   = bus.cache_data_out_ready && !bus.cache_busy;
        bad    = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
        mask   = bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
                 bus.req_size == 2'b01 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        din    = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                 bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
        b      = 8'(bus.cache_data_out >> {lane, 3'b000});
        h      = lane[1] ? bus.cache_data_out[31:16] : bus.cache_data_out[15:0];
        ldata  = size == 2'b00 ? {{24{sgn && b[7]}}, b} :
                 size == 2'b01 ? {{16{sgn && h[15]}}, h} : bus.cache_data_out;
    end

    // Errors answer straight from IDLE; cache outputs move only for legal requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid          <= 1'b0;
            bus.rsp_rdata          <= '0;
            bus.rsp_error          <= 1'b0;
            bus.cache_address      <= '0;
            bus.cache_data_in      <= '0;
            bus.cache_write_enable <= '0;
            cnt                    <= '0;
            lane                   <= '0;
            size                   <= '0;
            sgn                    <= 1'b0;
            wr                     <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (accept && bad) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_error <= 1'b1;
                bus.rsp_rdata <= '0;
            end else if (accept) begin
                bus.cache_address      <= {bus.req_addr[31:2], 2'b00};
                bus.cache_write_enable <= bus.req_write ? mask : 4'b0000;
                if (bus.req_write) bus.cache_data_in <= din;
                cnt  <= 2'(SETTLE_CYCLES - 1);
                lane <= bus.req_addr[1:0];
                size <= bus.req_size;
                sgn  <= bus.req_signed;
                wr   <= bus.req_write;
            end
            if (state == SETTLE && cnt != 2'd0) cnt <= cnt - 2'd1;
            if ((state == READ_WAIT || state == WRITE_WAIT) && done) begin
                bus.rsp_valid          <= 1'b1;
                bus.rsp_error          <= 1'b0;
                bus.rsp_rdata          <= state == READ_WAIT ? ldata : 32'd0;
                bus.cache_write_enable <= 4'b0000;
            end
        end
    end
endmodule

// File: doc/ram_io.md
# ram_io

Load/store adapter between a core-side memory request port and the 32-bit word port of the `Cache` block. It accepts one byte, halfword or word access at a time and drives the cache's `address`/`data_in`/`write_enable` inputs as follows:
- aligns the address to the word;
- generates byte-lane write masks and replicates write data across lanes;
- waits out cache misses;
- extracts and sign- or zero-extends load data.

Misaligned or illegal-size requests are rejected without touching the cache.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles after a new `cache_address` during which `cache_data_out_ready` is ignored. Legal values are 1–3.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend load result (ignored for word and for stores).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (bits [7:0] for a byte, [15:0] for a halfword).
- `rsp_valid` out 1: one-cycle completion pulse. There is no backpressure on the response.
- `rsp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `rsp_error` out 1: request was misaligned or illegal. Valid only with `rsp_valid`.
- `cache_address` out 32: word-aligned address to the cache, so bits [1:0] are always 0.
- `cache_data_in` out 32: write data to the cache.
- `cache_write_enable` out 4: byte-lane write mask to the cache.
- `cache_data_out` in 32: cache read word.
- `cache_data_out_ready` in 1: addressed line is resident and `cache_data_out` is valid.
- `cache_busy` in 1: cache is filling or evicting a line.

## Operation
- States: IDLE, SETTLE, READ_WAIT, WRITE_WAIT.
- `req_ready = (state == IDLE) && !cache_busy && !rst`. A request is accepted on `req_valid && req_ready`; all request fields are registered at acceptance.
- Error checks at acceptance:
  - `req_size == 11` → error.
  - Halfword with `addr[0] == 1` → error.
  - Word with `addr[1:0] != 0` → error.
  - On error: stay in IDLE, pulse `rsp_valid` with `rsp_error = 1` and `rsp_rdata = 0` on the next cycle, and leave all cache outputs unchanged.
- Legal request: register `cache_address = {addr[31:2], 2'b00}`, then go to SETTLE for `SETTLE_CYCLES` cycles.
- Stores:
  - `cache_data_in` replicates the data: byte → `{4{wdata[7:0]}}`, halfword → `{2{wdata[15:0]}}`, word → `wdata`.
  - `cache_write_enable`: byte → `4'b0001 << addr[1:0]`; halfword → `4'b0011` if `addr[1] == 0`, else `4'b1100`; word → `4'b1111`.
  - The mask is asserted in the same cycle `cache_address` changes and held through SETTLE and WRITE_WAIT.
- Loads: `cache_write_enable = 0` throughout.
- SETTLE → READ_WAIT for loads, → WRITE_WAIT for stores.
- READ_WAIT completes when `cache_data_out_ready && !cache_busy`:
  - Select the byte at lane `addr[1:0]` or the halfword at `addr[1]`.
  - Extend per `req_signed` and size.
  - Register the result into `rsp_rdata` and pulse `rsp_valid` on the next cycle while returning to IDLE.
- WRITE_WAIT completes on the same condition. The cache commits the write on that cycle. `cache_write_enable` drops to 0 and `rsp_valid` pulses on the next cycle, returning to IDLE.
- `rsp_rdata` and `rsp_error` hold their values until the next response. Only `rsp_valid` pulses.

## Timing
- Reset values: `req_ready = 0`, `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_error = 0`, `cache_address = 0`, `cache_data_in = 0`, `cache_write_enable = 0`; state is IDLE.
- Reset asserted in any state aborts the operation. `cache_write_enable` is 0 on the cycle after `rst` is sampled high, and no `rsp_valid` is produced for the aborted request.
- Latency with `SETTLE_CYCLES = 1`, request accepted at cycle T:
  - Error: `rsp_valid` at T+1.
  - Hit (ready and not busy at T+2): `rsp_valid` at T+3.
  - Miss: `rsp_valid` one cycle after the first cycle with `cache_data_out_ready && !cache_busy`.
- Back-to-back: `req_ready` reasserts in the cycle `rsp_valid` is high (when `cache_busy = 0`), giving one access per 3 cycles on hits.
- `cache_data_out_ready` is never sampled during SETTLE, even if high.
- `cache_busy` high in IDLE blocks acceptance only; it does not affect an error response already in flight.

## Test plan
- Load lanes: cache word at 0x10 is 0x80817F02.
  - lb 0x12 signed → `rsp_rdata` 0xFFFFFF81.
  - lbu 0x12 → 0x00000081.
  - lh 0x12 signed → 0xFFFF8081.
  - lhu 0x10 → 0x00007F02.
  - lw 0x10 → 0x80817F02.
  - Each completes with `rsp_valid` at T+3 and `cache_address` 0x10.
- sb 0x13 with wdata 0x000000AB → `cache_write_enable` 4'b1000 and `cache_data_in` 0xABABABAB from T+1 to T+2; enable is 0 and `rsp_valid` = 1 at T+3.
- sh 0x11 and lw 0x06 → `rsp_error` = 1 at T+1; `cache_write_enable` stays 0 and `cache_address` is unchanged.
- Miss: lw 0x40 with `cache_busy` high for 20 cycles starting at T+2 and ready asserted afterwards → `rsp_valid` exactly one cycle after ready and not busy; no early response from a stale ready during SETTLE.
- `rst` pulsed during WRITE_WAIT of a sw → `cache_write_enable` is 0 on the next cycle and no `rsp_valid`; a following lw completes normally.
- Back-to-back lw hits to 0x0, 0x4, 0x8 with `req_valid` held high → acceptances at cycles T, T+3, T+6.
